// File: rtl/sort4_result_checker.sv
// sort4_result_checker
//   Self-check block for the 4-word sort stream. Collects one group of four
//   words from the sorter, checks that the group is non-increasing and that
//   its head matches the max value the sorter reported, then pulses a
//   pass/fail result and keeps saturating group and error counts.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_in_valid   word/first/exp_max valid this cycle
//   i_in_first   word is slot 0 of a new group (qualified by i_in_valid)
//   i_in_data    sorted word from the sorter
//   i_exp_max    sorter's max output, sampled with the first word only
//   o_frame_done one-cycle pulse, group result valid
//   o_frame_ok   group result, meaningful while o_frame_done=1
//   o_frame_head slot 0 of the last checked group
//   o_frame_cnt  completed groups, saturating
//   o_err_cnt    failed groups plus framing errors, saturating
//   o_sticky_err set on any error, cleared only by reset
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a first word
// COLLECT | slot 0 held, gathering slots 1..3
// CHECK   | result pulse cycle; also accepts a new first word

module sort4_result_checker #(
   parameter int DW    = 3,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  logic             i_in_first,
   input  logic [DW-1:0]    i_in_data,
   input  logic [DW-1:0]    i_exp_max,
   output logic             o_frame_done,
   output logic             o_frame_ok,
   output logic [DW-1:0]    o_frame_head,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_sticky_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CHECK   = 2'd2
   } state_t;

   state_t           r_state;
   logic [1:0]       r_idx;
   logic [DW-1:0]    r_slot0;
   logic [DW-1:0]    r_slot1;
   logic [DW-1:0]    r_slot2;
   logic [DW-1:0]    r_exp_max;

   logic             w_accept_first;
   logic             w_frame_err;
   logic             w_last;
   logic             w_ok;
   logic [1:0]       w_err_inc;
   logic [CNT_W+1:0] w_err_sum;
   logic [CNT_W-1:0] w_err_next;

   // Slot 3 is never stored: the check is evaluated on the edge that
   // accepts it, so the result is registered one cycle after the 4th word.
   assign w_accept_first = i_in_valid & i_in_first;
   assign w_frame_err    = (r_state == ST_COLLECT) & w_accept_first;
   assign w_last         = (r_state == ST_COLLECT) & i_in_valid & ~i_in_first
                           & (r_idx == 2'd3);
   assign w_ok           = (r_slot0 >= r_slot1) & (r_slot1 >= r_slot2)
                           & (r_slot2 >= i_in_data) & (r_slot0 == r_exp_max);

   // Framing error and failed check are counted together so a cycle with
   // both adds two, saturating.
   assign w_err_inc  = {1'b0, w_frame_err} + {1'b0, w_last & ~w_ok};
   assign w_err_sum  = {2'b00, o_err_cnt} + {{CNT_W{1'b0}}, w_err_inc};
   assign w_err_next = (w_err_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                           : w_err_sum[CNT_W-1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= 2'd0;
         r_slot0      <= '0;
         r_slot1      <= '0;
         r_slot2      <= '0;
         r_exp_max    <= '0;
         o_frame_done <= 1'b0;
         o_frame_ok   <= 1'b0;
         o_frame_head <= '0;
         o_frame_cnt  <= '0;
         o_err_cnt    <= '0;
         o_sticky_err <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         o_err_cnt    <= w_err_next;
         if (w_err_inc != 2'd0)
            o_sticky_err <= 1'b1;

         case (r_state)
            ST_IDLE, ST_CHECK: begin
               if (w_accept_first) begin
                  r_slot0   <= i_in_data;
                  r_exp_max <= i_exp_max;
                  r_idx     <= 2'd1;
                  r_state   <= ST_COLLECT;
               end else begin
                  r_state   <= ST_IDLE;
               end
            end
            ST_COLLECT: begin
               if (w_accept_first) begin
                  // partial group discarded, restart on the new head
                  r_slot0   <= i_in_data;
                  r_exp_max <= i_exp_max;
                  r_idx     <= 2'd1;
               end else if (i_in_valid) begin
                  if (r_idx == 2'd3) begin
                     o_frame_done <= 1'b1;
                     o_frame_ok   <= w_ok;
                     o_frame_head <= r_slot0;
                     if (o_frame_cnt != {CNT_W{1'b1}})
                        o_frame_cnt <= o_frame_cnt + 1'b1;
                     r_idx        <= 2'd0;
                     r_state      <= ST_CHECK;
                  end else begin
                     if (r_idx == 2'd1)
                        r_slot1 <= i_in_data;
                     else
                        r_slot2 <= i_in_data;
                     r_idx <= r_idx + 2'd1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_idx   <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort4_result_checker.sv
module tb_sort4_result_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_first = 1'b0;
   logic [2:0] in_data  = 3'd0;
   logic [2:0] exp_max  = 3'd0;

   logic       a_done, a_ok, a_sticky;
   logic [2:0] a_head;
   logic [7:0] a_fcnt, a_ecnt;
   logic       b_done, b_ok, b_sticky;
   logic [2:0] b_head;
   logic [1:0] b_fcnt, b_ecnt;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int n_done = 0;

   always #5 clk = ~clk;

   sort4_result_checker #(.DW(3), .CNT_W(8)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_first(in_first),
      .i_in_data(in_data), .i_exp_max(exp_max),
      .o_frame_done(a_done), .o_frame_ok(a_ok), .o_frame_head(a_head),
      .o_frame_cnt(a_fcnt), .o_err_cnt(a_ecnt), .o_sticky_err(a_sticky));

   sort4_result_checker #(.DW(3), .CNT_W(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_first(in_first),
      .i_in_data(in_data), .i_exp_max(exp_max),
      .o_frame_done(b_done), .o_frame_ok(b_ok), .o_frame_head(b_head),
      .o_frame_cnt(b_fcnt), .o_err_cnt(b_ecnt), .o_sticky_err(b_sticky));

   // Group-level reference: a group is a list of words opened by a first word.
   int q[$];
   int m_emax = 0;
   bit m_done = 0, m_ok = 0, m_sticky = 0;
   int m_head = 0, m_frames = 0, m_errs = 0;

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   always @(posedge clk) begin
      m_done = 0;
      if (rst) begin
         q.delete();
         m_ok = 0; m_head = 0; m_frames = 0; m_errs = 0; m_sticky = 0;
      end else if (in_valid) begin
         if (in_first) begin
            if (q.size() > 0) begin
               m_errs++;
               m_sticky = 1;
            end
            q.delete();
            q.push_back(int'(in_data));
            m_emax = int'(exp_max);
         end else if (q.size() > 0) begin
            q.push_back(int'(in_data));
            if (q.size() == 4) begin
               m_done   = 1;
               m_ok     = (q[0] >= q[1]) && (q[1] >= q[2]) && (q[2] >= q[3])
                          && (q[0] == m_emax);
               m_head   = q[0];
               m_frames++;
               if (!m_ok) begin
                  m_errs++;
                  m_sticky = 1;
               end
               q.delete();
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (a_done) n_done++;
         chk("done8",   int'(a_done),   int'(m_done));
         chk("ok8",     int'(a_ok),     int'(m_ok));
         chk("head8",   int'(a_head),   m_head);
         chk("fcnt8",   int'(a_fcnt),   sat(m_frames, 8));
         chk("ecnt8",   int'(a_ecnt),   sat(m_errs, 8));
         chk("sticky8", int'(a_sticky), int'(m_sticky));
         chk("done2",   int'(b_done),   int'(m_done));
         chk("ok2",     int'(b_ok),     int'(m_ok));
         chk("head2",   int'(b_head),   m_head);
         chk("fcnt2",   int'(b_fcnt),   sat(m_frames, 2));
         chk("ecnt2",   int'(b_ecnt),   sat(m_errs, 2));
         chk("sticky2", int'(b_sticky), int'(m_sticky));
      end
   end

   // Drive one cycle of input; returns 1 time unit after the edge that samples it.
   task automatic drv(input bit v, input bit f, input int d, input int e);
      in_valid = v;
      in_first = f;
      in_data  = 3'(d);
      exp_max  = 3'(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      rst = 1'b0;
   endtask

   task automatic group4(input int w0, w1, w2, w3, input int e);
      drv(1, 1, w0, e);
      drv(1, 0, w1, 0);
      drv(1, 0, w2, 0);
      drv(1, 0, w3, 0);
   endtask

   int nd0;
   int g[4];
   int t;

   initial begin
      idle();
      chk_en = 1'b1;
      chk("rst_fcnt", int'(a_fcnt), 0);
      chk("rst_head", int'(a_head), 0);
      do_reset();

      // 1: passing group, result one cycle after the 4th word
      nd0 = n_done;
      group4(7, 5, 5, 1, 7);
      chk("t1_done", int'(a_done), 1);
      chk("t1_ok",   int'(a_ok),   1);
      chk("t1_head", int'(a_head), 7);
      chk("t1_fcnt", int'(a_fcnt), 1);
      chk("t1_ecnt", int'(a_ecnt), 0);
      idle();
      chk("t1_pulse", n_done - nd0, 1);

      // 2: order failure then max mismatch
      do_reset();
      group4(3, 4, 2, 1, 4);
      chk("t2a_ok",     int'(a_ok),     0);
      chk("t2a_ecnt",   int'(a_ecnt),   1);
      chk("t2a_sticky", int'(a_sticky), 1);
      idle();
      group4(6, 6, 6, 6, 5);
      chk("t2b_ok",   int'(a_ok),   0);
      chk("t2b_ecnt", int'(a_ecnt), 2);
      idle();

      // 3: framing error, then recovered group
      do_reset();
      nd0 = n_done;
      drv(1, 1, 7, 7);
      drv(1, 0, 6, 0);
      drv(1, 1, 5, 5);
      chk("t3_ecnt", int'(a_ecnt), 1);
      drv(1, 0, 3, 0);
      drv(1, 0, 2, 0);
      drv(1, 0, 0, 0);
      chk("t3_ok",   int'(a_ok),   1);
      chk("t3_fcnt", int'(a_fcnt), 1);
      chk("t3_pulse", n_done - nd0, 0);
      idle();

      // 4: back-to-back groups, then a gappy third group
      do_reset();
      nd0 = n_done;
      group4(7, 6, 5, 4, 7);
      group4(3, 3, 2, 0, 3);
      drv(1, 1, 5, 5); idle();
      drv(1, 0, 4, 0); idle();
      drv(1, 0, 4, 0); idle();
      drv(1, 0, 1, 0);
      idle();
      chk("t4_pulses", n_done - nd0, 3);
      chk("t4_fcnt", int'(a_fcnt), 3);
      chk("t4_ecnt", int'(a_ecnt), 0);

      // 5: saturation on the narrow instance
      do_reset();
      for (int i = 0; i < 5; i++) begin
         group4(1, 2, 3, 4, 4);
         idle();
      end
      chk("t5_fcnt2", int'(b_fcnt), 3);
      chk("t5_ecnt2", int'(b_ecnt), 3);
      chk("t5_fcnt8", int'(a_fcnt), 5);
      chk("t5_ecnt8", int'(a_ecnt), 5);

      // 6: reset mid-group
      nd0 = n_done;
      drv(1, 1, 7, 7);
      drv(1, 0, 6, 0);
      do_reset();
      chk("t6_done",   int'(a_done),   0);
      chk("t6_fcnt",   int'(a_fcnt),   0);
      chk("t6_ecnt",   int'(a_ecnt),   0);
      chk("t6_sticky", int'(a_sticky), 0);
      chk("t6_head",   int'(a_head),   0);
      idle(); idle();
      chk("t6_pulse", n_done - nd0, 0);
      group4(4, 3, 2, 1, 4);
      chk("t6_ok",   int'(a_ok),   1);
      chk("t6_fcnt1", int'(a_fcnt), 1);

      // random traffic: mostly whole groups, some truncated, strays, gaps, resets
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 60) == 0) do_reset();
         if ($urandom_range(0, 7) == 0) drv(1, 0, $urandom_range(0, 7), 0);
         for (int k = 0; k < 4; k++) g[k] = $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            for (int a = 0; a < 3; a++)
               for (int b = 0; b < 3 - a; b++)
                  if (g[b] < g[b+1]) begin
                     t = g[b]; g[b] = g[b+1]; g[b+1] = t;
                  end
         end
         t = $urandom_range(1, 8);
         for (int k = 0; k < 4 && (t == 1 ? k < 2 : 1); k++) begin
            while ($urandom_range(0, 3) == 0) idle();
            if (k == 0)
               drv(1, 1, g[0], ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : g[0]);
            else
               drv(1, 0, g[k], $urandom_range(0, 7));
         end
         if ($urandom_range(0, 2) == 0) idle();
      end
      idle(); idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
